// File: rtl/idle_rate_matcher.sv
// 66b elastic buffer with idle delete/insert rate matching, paced output and a BIST bypass mux.
// The read side emits at most one word per non-gap cycle of the pacing period.
module idle_rate_matcher #(
    parameter int unsigned DAT_W      = 64,
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned HIGH_MARK  = 21,
    parameter int unsigned LOW_MARK   = 8,
    parameter int unsigned GAP_PERIOD = 33,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                     CLK219,
    input  logic                     RST219,
    input  logic                     lpbk_en,
    input  logic                     rx_sync,
    input  logic [DAT_W-1:0]         RX_DAT,
    input  logic [1:0]               RX_SH,
    input  logic                     RX_VAL,
    input  logic [DAT_W-1:0]         BIST_DAT,
    input  logic [1:0]               BIST_SH,
    input  logic                     BIST_VAL,
    input  logic                     cnt_clr,
    output logic [DAT_W-1:0]         MUX_DAT,
    output logic [1:0]               MUX_SH,
    output logic                     MUX_VAL,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic [CNT_W-1:0]         ins_cnt,
    output logic [CNT_W-1:0]         del_cnt,
    output logic                     ovf,
    output logic                     udf
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned FW = AW + 1;
    localparam int unsigned PW = $clog2(GAP_PERIOD);
    localparam int unsigned WW = DAT_W + 2;

    localparam logic [FW-1:0] HighMark = FW'(HIGH_MARK);
    localparam logic [FW-1:0] LowMark  = FW'(LOW_MARK);
    localparam logic [FW-1:0] HalfMark = FW'(DEPTH / 2);
    localparam logic [FW-1:0] FullMark = FW'(DEPTH);
    localparam logic [PW-1:0] GapLast  = PW'(GAP_PERIOD - 1);
    localparam logic [WW-1:0] IdleWord = {2'b01, DAT_W'(8'h1E)};

    typedef enum logic [0:0] {StPrefill, StRun} state_e;

    function automatic logic is_idle(input logic [WW-1:0] w);
        return (w[WW-1:DAT_W] == 2'b01) && (w[7:0] == 8'h1E);
    endfunction

    logic [WW-1:0]    rx_q;
    logic             rx_val_q;
    logic [WW-1:0]    mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FW-1:0]    fill_q, fill_d;
    state_e           state_q, state_d;
    logic [PW-1:0]    pace_q, pace_d;
    logic             last_wr_idle_q, last_wr_idle_d, last_rd_idle_q, last_rd_idle_d;
    logic [DAT_W-1:0] mux_dat_q, mux_dat_d;
    logic [1:0]       mux_sh_q, mux_sh_d;
    logic             mux_val_q, mux_val_d;
    logic [CNT_W-1:0] ins_cnt_q, ins_cnt_d, del_cnt_q, del_cnt_d;
    logic             ovf_q, ovf_d, udf_q, udf_d;

    logic          flush, slot, wr_idle, full, del_en, ovf_evt, wr_en;
    logic          rd_slot, udf_evt, ins_en, pop_en;
    logic [WW-1:0] emit;

    assign flush   = !rx_sync || !lpbk_en;
    assign slot    = (pace_q != GapLast);
    assign wr_idle = is_idle(rx_q);
    assign full    = (fill_q == FullMark);
    // A second consecutive idle is dropped only while the buffer runs high.
    assign del_en  = !flush && rx_val_q && wr_idle && last_wr_idle_q && (fill_q >= HighMark);
    assign ovf_evt = !flush && rx_val_q && !del_en && full;
    assign wr_en   = !flush && rx_val_q && !del_en && !full;
    assign rd_slot = !flush && (state_q == StRun) && slot;
    assign udf_evt = rd_slot && (fill_q == '0);
    assign ins_en  = rd_slot && !udf_evt && last_rd_idle_q && (fill_q <= LowMark);
    assign pop_en  = rd_slot && !udf_evt && !ins_en;
    assign emit    = ins_en ? IdleWord : (pop_en ? mem_q[rd_ptr_q] : '0);

    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        fill_d         = fill_q;
        state_d        = state_q;
        last_wr_idle_d = last_wr_idle_q;
        last_rd_idle_d = last_rd_idle_q;
        pace_d         = (pace_q == GapLast) ? '0 : pace_q + 1'b1;
        if (flush) begin
            wr_ptr_d       = '0;
            rd_ptr_d       = '0;
            fill_d         = '0;
            state_d        = StPrefill;
            last_wr_idle_d = 1'b0;
            last_rd_idle_d = 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_d       = wr_ptr_q + 1'b1;
                last_wr_idle_d = wr_idle;
            end
            if (pop_en) rd_ptr_d = rd_ptr_q + 1'b1;
            fill_d = fill_q + FW'(wr_en) - FW'(pop_en);
            if (ins_en || pop_en) last_rd_idle_d = is_idle(emit);
            if (udf_evt) begin
                state_d        = StPrefill;
                last_rd_idle_d = 1'b0;
            end else if (state_q == StPrefill && fill_q >= HalfMark) begin
                state_d = StRun;
            end
        end
    end

    always_comb begin
        mux_dat_d = mux_dat_q;
        mux_sh_d  = mux_sh_q;
        mux_val_d = mux_val_q;
        if (!lpbk_en) begin
            mux_dat_d = BIST_DAT;
            mux_sh_d  = BIST_SH;
            mux_val_d = BIST_VAL;
        end else begin
            mux_val_d = slot;
            // Outside RUN (or on underflow) emit is zero, forcing SH=00 downstream.
            if (slot) begin
                mux_sh_d  = emit[WW-1:DAT_W];
                mux_dat_d = emit[DAT_W-1:0];
            end
        end
    end

    always_comb begin
        ins_cnt_d = ins_cnt_q;
        del_cnt_d = del_cnt_q;
        ovf_d     = ovf_q;
        udf_d     = udf_q;
        if (cnt_clr) begin
            ins_cnt_d = '0;
            del_cnt_d = '0;
            ovf_d     = 1'b0;
            udf_d     = 1'b0;
        end else begin
            if (ins_en && !(&ins_cnt_q)) ins_cnt_d = ins_cnt_q + 1'b1;
            if (del_en && !(&del_cnt_q)) del_cnt_d = del_cnt_q + 1'b1;
            if (ovf_evt) ovf_d = 1'b1;
            if (udf_evt) udf_d = 1'b1;
        end
    end

    always_ff @(posedge CLK219) begin
        if (wr_en) mem_q[wr_ptr_q] <= rx_q;
    end

    always_ff @(posedge CLK219 or posedge RST219) begin
        if (RST219) begin
            rx_q           <= '0;
            rx_val_q       <= 1'b0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            fill_q         <= '0;
            state_q        <= StPrefill;
            pace_q         <= '0;
            last_wr_idle_q <= 1'b0;
            last_rd_idle_q <= 1'b0;
            mux_dat_q      <= '0;
            mux_sh_q       <= '0;
            mux_val_q      <= 1'b0;
            ins_cnt_q      <= '0;
            del_cnt_q      <= '0;
            ovf_q          <= 1'b0;
            udf_q          <= 1'b0;
        end else begin
            rx_q           <= {RX_SH, RX_DAT};
            rx_val_q       <= RX_VAL;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            fill_q         <= fill_d;
            state_q        <= state_d;
            pace_q         <= pace_d;
            last_wr_idle_q <= last_wr_idle_d;
            last_rd_idle_q <= last_rd_idle_d;
            mux_dat_q      <= mux_dat_d;
            mux_sh_q       <= mux_sh_d;
            mux_val_q      <= mux_val_d;
            ins_cnt_q      <= ins_cnt_d;
            del_cnt_q      <= del_cnt_d;
            ovf_q          <= ovf_d;
            udf_q          <= udf_d;
        end
    end

    assign MUX_DAT    = mux_dat_q;
    assign MUX_SH     = mux_sh_q;
    assign MUX_VAL    = mux_val_q;
    assign fill_level = fill_q;
    assign ins_cnt    = ins_cnt_q;
    assign del_cnt    = del_cnt_q;
    assign ovf        = ovf_q;
    assign udf        = udf_q;
endmodule

// File: tb/tb_idle_rate_matcher.sv
// Randomized bench for idle_rate_matcher: a queue-based reference model predicts every output
// each cycle; narrow counters make saturation reachable.
module tb_idle_rate_matcher;
    localparam int DAT_W = 64;
    localparam int DEPTH = 32;
    localparam int HIGH  = 21;
    localparam int LOW   = 8;
    localparam int GAP   = 33;
    localparam int CNT_W = 4;
    localparam int AW    = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             lpbk_en = 1'b0, rx_sync = 1'b0, cnt_clr = 1'b0;
    logic [DAT_W-1:0] rx_dat = '0, bist_dat = '0;
    logic [1:0]       rx_sh = '0, bist_sh = '0;
    logic             rx_val = 1'b0, bist_val = 1'b0;
    logic [DAT_W-1:0] mux_dat;
    logic [1:0]       mux_sh;
    logic             mux_val;
    logic [AW:0]      fill_level;
    logic [CNT_W-1:0] ins_cnt, del_cnt;
    logic             ovf, udf;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    idle_rate_matcher #(
        .DAT_W(DAT_W), .DEPTH(DEPTH), .HIGH_MARK(HIGH), .LOW_MARK(LOW),
        .GAP_PERIOD(GAP), .CNT_W(CNT_W)
    ) dut (
        .CLK219(clk), .RST219(rst), .lpbk_en(lpbk_en), .rx_sync(rx_sync),
        .RX_DAT(rx_dat), .RX_SH(rx_sh), .RX_VAL(rx_val),
        .BIST_DAT(bist_dat), .BIST_SH(bist_sh), .BIST_VAL(bist_val),
        .cnt_clr(cnt_clr), .MUX_DAT(mux_dat), .MUX_SH(mux_sh), .MUX_VAL(mux_val),
        .fill_level(fill_level), .ins_cnt(ins_cnt), .del_cnt(del_cnt), .ovf(ovf), .udf(udf)
    );

    // Reference model state
    logic [65:0] mq[$];
    bit          m_run, m_lwi, m_lri, m_rx_v, m_val, m_ovf, m_udf;
    int          m_pace, m_ins, m_del;
    logic [1:0]  m_rx_sh, m_sh;
    logic [63:0] m_rx_dat, m_dat;

    function automatic bit idle_word(input logic [65:0] w);
        return (w[65:64] == 2'b01) && (w[7:0] == 8'h1E);
    endfunction

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        mq.delete();
        m_run = 0; m_lwi = 0; m_lri = 0; m_rx_v = 0; m_val = 0; m_ovf = 0; m_udf = 0;
        m_pace = 0; m_ins = 0; m_del = 0;
        m_rx_sh = '0; m_sh = '0; m_rx_dat = '0; m_dat = '0;
    endtask

    task automatic model_step();
        bit flush, slot, wr_idle, del_e, ovf_e, wr_e, und_e, ins_e, pop_e;
        int fill;
        logic [65:0] emit;
        flush   = !rx_sync || !lpbk_en;
        fill    = mq.size();
        slot    = (m_pace != GAP - 1);
        wr_idle = idle_word({m_rx_sh, m_rx_dat});
        del_e   = !flush && m_rx_v && wr_idle && m_lwi && fill >= HIGH;
        ovf_e   = !flush && m_rx_v && !del_e && fill == DEPTH;
        wr_e    = !flush && m_rx_v && !del_e && fill != DEPTH;
        und_e   = !flush && m_run && slot && fill == 0;
        ins_e   = !flush && m_run && slot && fill != 0 && m_lri && fill <= LOW;
        pop_e   = !flush && m_run && slot && fill != 0 && !ins_e;
        emit    = ins_e ? {2'b01, 64'h1E} : (pop_e ? mq[0] : 66'd0);
        if (!lpbk_en) begin
            m_sh = bist_sh; m_dat = bist_dat; m_val = bist_val;
        end else begin
            m_val = slot;
            if (slot) begin
                m_sh  = emit[65:64];
                m_dat = emit[63:0];
            end
        end
        if (flush) begin
            mq.delete(); m_run = 0; m_lwi = 0; m_lri = 0;
        end else begin
            if (pop_e) void'(mq.pop_front());
            if (wr_e) begin
                mq.push_back({m_rx_sh, m_rx_dat});
                m_lwi = wr_idle;
            end
            if (ins_e || pop_e) m_lri = idle_word(emit);
            if (und_e) begin
                m_run = 0; m_lri = 0;
            end else if (!m_run && fill >= DEPTH / 2) begin
                m_run = 1;
            end
        end
        if (cnt_clr) begin
            m_ins = 0; m_del = 0; m_ovf = 0; m_udf = 0;
        end else begin
            if (ins_e && m_ins < (1 << CNT_W) - 1) m_ins++;
            if (del_e && m_del < (1 << CNT_W) - 1) m_del++;
            if (ovf_e) m_ovf = 1;
            if (und_e) m_udf = 1;
        end
        m_pace   = (m_pace + 1) % GAP;
        m_rx_v   = rx_val;
        m_rx_sh  = rx_sh;
        m_rx_dat = rx_dat;
    endtask

    always @(posedge clk) begin
        if (rst) model_reset();
        else model_step();
    end

    task automatic check_outputs();
        check_val("mux_val", 128'(mux_val), 128'(m_val));
        check_val("mux_sh", 128'(mux_sh), 128'(m_sh));
        check_val("mux_dat", 128'(mux_dat), 128'(m_dat));
        check_val("fill_level", 128'(fill_level), 128'(mq.size()));
        check_val("ins_cnt", 128'(ins_cnt), 128'(m_ins));
        check_val("del_cnt", 128'(del_cnt), 128'(m_del));
        check_val("ovf", 128'(ovf), 128'(m_ovf));
        check_val("udf", 128'(udf), 128'(m_udf));
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic set_data();
        rx_val = 1'b1; rx_sh = 2'b10; rx_dat = {$urandom, $urandom};
    endtask

    task automatic set_idle();
        rx_val = 1'b1; rx_sh = 2'b01;
        rx_dat = {$urandom, ($urandom & 32'hFFFF_FF00) | 32'h1E};
    endtask

    initial begin
        int pair;
        model_reset();
        repeat (3) @(negedge clk);
        check_val("reset_mux", 128'({mux_val, mux_sh, mux_dat}), 128'(0));
        check_val("reset_stat", 128'({fill_level, ins_cnt, del_cnt, ovf, udf}), 128'(0));
        check_outputs();
        rst = 1'b0; lpbk_en = 1'b1; rx_sync = 1'b1;

        // Continuous data from reset: prefill, then paced in-order output
        for (int i = 0; i < 120; i++) begin set_data(); tick(); end

        // Idle pairs at full input rate drive fill past the high mark
        pair = 0;
        for (int i = 0; i < 700; i++) begin
            if (pair > 0) begin set_idle(); pair--; end
            else if ($urandom_range(0, 2) == 0) begin set_idle(); pair = 1; end
            else set_data();
            cnt_clr = ($urandom_range(0, 99) == 0);
            tick();
        end
        cnt_clr = 1'b0;

        // Half-rate input with idles drains fill and triggers insertion
        for (int i = 0; i < 400; i++) begin
            if (i % 2 == 0) begin
                if ($urandom_range(0, 1) == 0) set_idle(); else set_data();
            end else rx_val = 1'b0;
            cnt_clr = ($urandom_range(0, 49) == 0);
            tick();
        end
        cnt_clr = 1'b0;

        // Underflow: flush, prefill with data only, then starve
        rx_sync = 1'b0; rx_val = 1'b0;
        repeat (3) tick();
        rx_sync = 1'b1;
        for (int i = 0; i < 40; i++) begin set_data(); tick(); end
        rx_val = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        check_val("udf_set", 128'(udf), 128'(1));
        check_val("udf_fill", 128'(fill_level), 128'(0));

        // Overflow: continuous data until the buffer saturates, then lose sync
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        for (int i = 0; i < 700; i++) begin set_data(); tick(); end
        check_val("ovf_set", 128'(ovf), 128'(1));
        rx_sync = 1'b0;
        tick();
        check_val("sync_loss_fill", 128'(fill_level), 128'(0));
        tick();
        check_val("sync_loss_out", 128'({mux_sh, mux_dat}), 128'(0));

        // BIST mode: straight 1-cycle passthrough
        lpbk_en = 1'b0; rx_sync = 1'b1;
        for (int i = 0; i < 60; i++) begin
            bist_dat = {$urandom, $urandom};
            bist_sh  = 2'($urandom_range(0, 3));
            bist_val = 1'($urandom_range(0, 1));
            set_data();
            cnt_clr = ($urandom_range(0, 9) == 0);
            tick();
        end
        cnt_clr = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
